// File: rtl/safe_ctrl.sv
// Code-lock controller: stores a user code from save/lock button pulses, verifies
// unlock attempts and holds a timed alarm after too many consecutive failures.
module safe_ctrl #(
  parameter int SECONDS       = 50_000_000,
  parameter int DIGITS        = 4,
  parameter int MAX_TRIES     = 3,
  parameter int ALARM_SECONDS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       save,
  input  logic       lock,
  input  logic [3:0] digit,
  output logic       locked,
  output logic       alarm,
  output logic       bad,
  output logic [2:0] count
);

  localparam int          CODE_W     = 4 * DIGITS;
  localparam logic [2:0]  FULL       = 3'(DIGITS);
  localparam logic [2:0]  TRIES_MAX  = 3'(MAX_TRIES);
  localparam logic [31:0] ALARM_LOAD = 32'(ALARM_SECONDS * SECONDS - 1);

  typedef enum logic [1:0] {
    ST_OPEN   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_ALARM  = 2'd2
  } state_t;

  state_t              state_r;
  logic [CODE_W-1:0]   entry_r;
  logic [CODE_W-1:0]   code_r;
  logic [2:0]          tries_r;
  logic [31:0]         timer_r;

  logic [CODE_W-1:0]   entry_next_s;
  logic                take_save_s;
  logic                match_s;
  logic [2:0]          tries_inc_s;

  // Next entry buffer with the incoming digit placed in slot 'count', plus decode helpers.
  always_comb begin
    entry_next_s = entry_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (count == 3'(i)) begin
        entry_next_s[4*i +: 4] = digit;
      end else begin
        entry_next_s[4*i +: 4] = entry_r[4*i +: 4];
      end
    end
    take_save_s = save && !lock && (count != FULL);
    match_s     = (count == FULL) && (entry_r == code_r);
    tries_inc_s = tries_r + 3'd1;
  end

  // Controller state machine with all outputs held in registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_OPEN;
      entry_r <= '0;
      code_r  <= '0;
      tries_r <= 3'd0;
      timer_r <= 32'd0;
      count   <= 3'd0;
      locked  <= 1'b0;
      alarm   <= 1'b0;
      bad     <= 1'b0;
    end else begin
      bad <= 1'b0;
      case (state_r)
        ST_OPEN: begin
          if (lock) begin
            count <= 3'd0;
            if (count == FULL) begin
              code_r  <= entry_r;
              state_r <= ST_LOCKED;
              locked  <= 1'b1;
            end
          end else if (take_save_s) begin
            entry_r <= entry_next_s;
            count   <= count + 3'd1;
          end
        end
        ST_LOCKED: begin
          if (lock) begin
            count <= 3'd0;
            if (match_s) begin
              state_r <= ST_OPEN;
              locked  <= 1'b0;
              tries_r <= 3'd0;
            end else begin
              bad     <= 1'b1;
              tries_r <= tries_inc_s;
              // Alarm keeps tries at the limit until it times out.
              if (tries_inc_s == TRIES_MAX) begin
                state_r <= ST_ALARM;
                alarm   <= 1'b1;
                timer_r <= ALARM_LOAD;
              end
            end
          end else if (take_save_s) begin
            entry_r <= entry_next_s;
            count   <= count + 3'd1;
          end
        end
        ST_ALARM: begin
          if (timer_r == 32'd0) begin
            state_r <= ST_LOCKED;
            alarm   <= 1'b0;
            tries_r <= 3'd0;
            count   <= 3'd0;
          end else begin
            timer_r <= timer_r - 32'd1;
          end
        end
        default: begin
          state_r <= ST_OPEN;
          tries_r <= 3'd0;
          count   <= 3'd0;
          locked  <= 1'b0;
          alarm   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_safe_ctrl.sv
// Self-checking bench for safe_ctrl: directed scenarios plus random button traffic,
// all compared against a queue-based behavioural model of the lock.
module tb_safe_ctrl;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       save  = 1'b0;
  logic       lock  = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       locked;
  logic       alarm;
  logic       bad;
  logic [2:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: 0=open, 1=locked, 2=alarm
  int m_mode;
  int m_code[4];
  int m_entry[$];
  int m_tries;
  int m_left;
  bit m_bad;

  safe_ctrl #(
    .SECONDS(4), .DIGITS(4), .MAX_TRIES(3), .ALARM_SECONDS(2)
  ) dut (
    .clk(clk), .rst(rst), .save(save), .lock(lock), .digit(digit),
    .locked(locked), .alarm(alarm), .bad(bad), .count(count)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_mode = 0;
    for (int i = 0; i < 4; i++) m_code[i] = 0;
    m_entry.delete();
    m_tries = 0;
    m_left  = 0;
    m_bad   = 1'b0;
  endfunction

  function automatic bit m_match();
    if (m_entry.size() != 4) return 1'b0;
    for (int i = 0; i < 4; i++) if (m_entry[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input logic s, input logic l, input logic [3:0] d);
    m_bad = 1'b0;
    if (m_mode == 2) begin
      m_left--;
      if (m_left == 0) begin
        m_mode  = 1;
        m_tries = 0;
        m_entry.delete();
      end
    end else if (l) begin
      if (m_mode == 0) begin
        if (m_entry.size() == 4) begin
          for (int i = 0; i < 4; i++) m_code[i] = m_entry[i];
          m_mode = 1;
        end
      end else if (m_match()) begin
        m_mode  = 0;
        m_tries = 0;
      end else begin
        m_bad = 1'b1;
        m_tries++;
        if (m_tries == 3) begin
          m_mode = 2;
          m_left = 8;
        end
      end
      m_entry.delete();
    end else if (s && m_entry.size() < 4) begin
      m_entry.push_back(int'(d));
    end
  endtask

  function automatic logic [5:0] exp_vec();
    return {(m_mode != 0), (m_mode == 2), m_bad, 3'(m_entry.size())};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {locked, alarm, bad, count};
  endfunction

  task automatic cycle(input logic s, input logic l, input logic [3:0] d);
    save = s; lock = l; digit = d;
    @(posedge clk);
    model_step(s, l, d);
    @(negedge clk);
    save = 1'b0; lock = 1'b0; digit = 4'd0;
  endtask

  task automatic enter(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) cycle(1'b1, 1'b0, v[4*i +: 4]);
  endtask

  task automatic quiet_reset();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (dut_vec() !== 6'b000000) $display("FAIL reset_active got %b want %b", dut_vec(), 6'b000000);
    else n_pass++;
    rst = 1'b1;
    cycle(1'b0, 1'b0, 4'd0);
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL reset_idle got %b want %b", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_set_code();
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 1'b0, 4'(i));
      n_checks++;
      if (dut_vec() !== {3'b000, 3'(i)}) $display("FAIL set_count got %b want %b", dut_vec(), {3'b000, 3'(i)});
      else n_pass++;
    end
    cycle(1'b0, 1'b1, 4'd0);
    n_checks++;
    if (dut_vec() !== 6'b100000) $display("FAIL set_lock got %b want %b", dut_vec(), 6'b100000);
    else n_pass++;
  endtask

  task automatic test_unlock();
    enter(32'h1234, 4);
    cycle(1'b0, 1'b1, 4'd0);
    n_checks++;
    if (dut_vec() !== 6'b000000) $display("FAIL unlock_ok got %b want %b", dut_vec(), 6'b000000);
    else n_pass++;
    enter(32'h56, 2);
    cycle(1'b0, 1'b1, 4'd0);
    n_checks++;
    if (dut_vec() !== 6'b000000) $display("FAIL open_short_lock got %b want %b", dut_vec(), 6'b000000);
    else n_pass++;
    enter(32'h1234, 4);
    cycle(1'b0, 1'b1, 4'd0);
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL relock got %b want %b", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_bad_attempts();
    enter(32'h1235, 4);
    cycle(1'b0, 1'b1, 4'd0);
    n_checks++;
    if (dut_vec() !== 6'b101000) $display("FAIL bad_wrong got %b want %b", dut_vec(), 6'b101000);
    else n_pass++;
    cycle(1'b0, 1'b0, 4'd0);
    n_checks++;
    if (bad !== 1'b0) $display("FAIL bad_one_cycle got %b want %b", bad, 1'b0);
    else n_pass++;
    enter(32'h12, 2);
    cycle(1'b0, 1'b1, 4'd0);
    n_checks++;
    if (dut_vec() !== 6'b101000) $display("FAIL bad_short got %b want %b", dut_vec(), 6'b101000);
    else n_pass++;
    enter(32'h1234, 4);
    cycle(1'b0, 1'b1, 4'd0);
    n_checks++;
    if (dut_vec() !== 6'b000000) $display("FAIL bad_then_ok got %b want %b", dut_vec(), 6'b000000);
    else n_pass++;
    enter(32'h1234, 4);
    cycle(1'b0, 1'b1, 4'd0);
  endtask

  task automatic test_alarm();
    int alarm_len;
    for (int k = 0; k < 3; k++) begin
      enter(32'h9999, 4);
      cycle(1'b0, 1'b1, 4'd0);
    end
    n_checks++;
    if (dut_vec() !== 6'b111000) $display("FAIL alarm_enter got %b want %b", dut_vec(), 6'b111000);
    else n_pass++;
    alarm_len = 1;
    for (int c = 0; c < 20 && alarm === 1'b1; c++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL alarm_hold got %b want %b", dut_vec(), exp_vec());
      else n_pass++;
      if (alarm === 1'b1) alarm_len++;
    end
    n_checks++;
    if (alarm_len != 8) $display("FAIL alarm_len got %0d want %0d", alarm_len, 8);
    else n_pass++;
    n_checks++;
    if (dut_vec() !== 6'b100000) $display("FAIL alarm_exit got %b want %b", dut_vec(), 6'b100000);
    else n_pass++;
    enter(32'h1234, 4);
    cycle(1'b0, 1'b1, 4'd0);
    n_checks++;
    if (dut_vec() !== 6'b000000) $display("FAIL alarm_unlock got %b want %b", dut_vec(), 6'b000000);
    else n_pass++;
  endtask

  task automatic test_saturate();
    enter(32'h12345, 5);
    n_checks++;
    if (dut_vec() !== 6'b000100) $display("FAIL sat_count got %b want %b", dut_vec(), 6'b000100);
    else n_pass++;
    cycle(1'b0, 1'b1, 4'd0);
    enter(32'h1234, 4);
    cycle(1'b0, 1'b1, 4'd0);
    n_checks++;
    if (dut_vec() !== 6'b000000) $display("FAIL sat_code got %b want %b", dut_vec(), 6'b000000);
    else n_pass++;
    enter(32'h123, 3);
    cycle(1'b1, 1'b1, 4'd4);
    n_checks++;
    if (dut_vec() !== 6'b000000) $display("FAIL save_lock_same got %b want %b", dut_vec(), 6'b000000);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), 4'($urandom_range(1, 2)));
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL random_%0d got %b want %b", c, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    quiet_reset();
    enter(32'h1234, 4);
    cycle(1'b0, 1'b1, 4'd0);
    for (int k = 0; k < 3; k++) begin
      enter(32'h1111, 4);
      cycle(1'b0, 1'b1, 4'd0);
    end
    repeat (3) cycle(1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec() !== 6'b000000) $display("FAIL reset_mid_alarm got %b want %b", dut_vec(), 6'b000000);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    enter(32'h12, 2);
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec() !== 6'b000000) $display("FAIL reset_mid_entry got %b want %b", dut_vec(), 6'b000000);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    enter(32'h0000, 4);
    cycle(1'b0, 1'b1, 4'd0);
    n_checks++;
    if (dut_vec() !== 6'b100000) $display("FAIL reset_code_lock got %b want %b", dut_vec(), 6'b100000);
    else n_pass++;
    enter(32'h0000, 4);
    cycle(1'b0, 1'b1, 4'd0);
    n_checks++;
    if (dut_vec() !== 6'b000000) $display("FAIL reset_code_unlock got %b want %b", dut_vec(), 6'b000000);
    else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_set_code();
    test_unlock();
    test_bad_attempts();
    test_alarm();
    test_saturate();
    quiet_reset();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/safe_ctrl.md
# safe_ctrl

Code-lock controller for the safe design. Sits directly downstream of the button-press classifier, consuming its one-cycle `save` (short press) and `lock` (long press) pulses together with a 4-bit digit switch bank. It stores a user code, locks the safe, verifies unlock attempts, and raises a timed alarm after repeated failures.

## Interface
- `SECONDS`, 50_000_000: clock cycles per second.
- `DIGITS`, 4: code length in digits (1..7).
- `MAX_TRIES`, 3: consecutive failed unlock attempts that trigger the alarm (1..7).
- `ALARM_SECONDS`, 10: alarm duration in seconds.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `save`  in  1  one-cycle pulse: append `digit` to the current entry.
- `lock`  in  1  one-cycle pulse: commit the entry (set code, or attempt unlock).
- `digit`  in  4  digit value, sampled only on the clock edge where `save`=1.
- `locked`  out  1  registered; 1 in LOCKED and ALARM.
- `alarm`  out  1  registered; 1 only in ALARM.
- `bad`  out  1  registered one-cycle pulse on each failed unlock attempt.
- `count`  out  3  registered number of digits entered so far (0..DIGITS).

## Operation
- States: OPEN, LOCKED, ALARM. All outputs are derived from registers.
- Reset (`rst`=0, any time, including mid-entry or mid-alarm):
  - state=OPEN; stored code all zeros; entry buffer cleared.
  - `count`=0, tries=0, timer=0.
  - `locked`=0, `alarm`=0, `bad`=0.
- `save` and `lock` in the same cycle: `lock` wins and the `save` is dropped.
- `save` with `count`=DIGITS is ignored; `count` saturates.
- OPEN:
  - `save`: `digit` is written into entry slot `count`; `count`+1.
  - `lock` with `count`=DIGITS: entry is copied to the stored code; `count`→0; →LOCKED.
  - `lock` with `count`<DIGITS: `count`→0; stays OPEN; stored code unchanged.
- LOCKED:
  - `save`: same digit entry as in OPEN.
  - `lock`, when `count`=DIGITS and entry equals the stored code: →OPEN; tries→0; `count`→0.
  - `lock` otherwise (wrong code or short entry):
    - `bad` pulses; `count`→0; tries+1.
    - If the new tries equals MAX_TRIES: →ALARM; timer loaded with ALARM_SECONDS*SECONDS−1.
- ALARM:
  - `save`/`lock` are ignored.
  - Timer decrements once per cycle.
  - At timer=0: →LOCKED; tries→0; `count`→0.
  - The stored code is kept.
- Timer is 32-bit unsigned. ALARM_SECONDS*SECONDS must fit in 32 bits.
- tries and `count` are 3-bit.

## Timing
- Input pulse at edge n → resulting state and output changes are visible after edge n (cycle n+1). Latency is 1 cycle.
- `bad` is high for exactly the one cycle after the failing `lock`.
- `alarm` is high for exactly ALARM_SECONDS*SECONDS cycles. `locked` stays 1 throughout and after.
- A `lock` arriving the cycle after ALARM exits is processed normally in LOCKED.
- Back-to-back `save` pulses on consecutive cycles are each accepted.

## Test plan
Use SECONDS=4, ALARM_SECONDS=2 (alarm = 8 cycles), DIGITS=4, MAX_TRIES=3.
- Reset, then save 1,2,3,4 and lock → `count` steps 1,2,3,4,0; `locked`=1 the cycle after `lock`; `bad`=0.
- From LOCKED with code 1234: save 1,2,3,4, then lock → `locked`=0, tries=0. Next, save 5,6 then lock → stays OPEN, `count`=0, `locked`=0.
- From LOCKED, enter 1235 + lock, then 12 + lock → two `bad` pulses, `locked`=1; then 1234 + lock → `locked`=0 (tries cleared by the success).
- Three wrong attempts → `alarm`=1 for exactly 8 cycles. Save/lock during the alarm are ignored (`count` stays 0). After the alarm, `locked`=1; entering 1234 + lock unlocks.
- Five saves then lock in OPEN → `count` saturates at 4; the code is the first four digits. Also: same-cycle save+lock → lock taken, digit dropped.
- Assert `rst`=0 mid-alarm and mid-entry → immediately `alarm`=0, `locked`=0, `count`=0. After release, the stored code is 0000 (lock with entry 0000 accepted as the new code).
